delay_chain_sensor: RTL and testbench

Parametrised on-chip delay sensor. It drives a tapped chain of NUM_STAGES inverting delay stages and captures every tap one clock after launching a transition. It converts the captured taps to a propagation depth and averages that depth over 2^SAMPLES_LOG2 launches. It sits between the spy delay chains and the measurement/readout logic, replacing fixed-length, untapped chains with a measured, repeatable depth value.

---
 rtl/delay_sensor_pkg.sv | 38 +++
 rtl/delay_chain_sensor_if.sv | 23 ++
 rtl/delay_chain_taps.sv | 19 +
 rtl/delay_chain_sensor.sv | 122 ++++++++++++
 tb/tb_delay_chain_sensor.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/delay_sensor_pkg.sv
// Shared state type and helpers for the tapped delay-chain sensor.
package delay_sensor_pkg;

  localparam int MAX_STAGES = 256;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    CAPTURE,
    SYNC,
    ENCODE,
    SETTLE,
    DONE
  } state_t;

  function automatic int cnt_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  // Tap k sits behind k+1 inverters, so even taps are flipped back before
  // comparing; the run ends at the first mismatch so later bubbles are ignored.
  function automatic int tap_depth(input logic [MAX_STAGES-1:0] taps,
                                   input int num_stages,
                                   input logic level);
    int depth;
    logic run;
    depth = 0;
    run = 1'b1;
    for (int k = 0; k < MAX_STAGES; k++) begin
      if (run && (k < num_stages)) begin
        if ((taps[k] ^ ~k[0]) == level) depth++;
        else run = 1'b0;
      end
    end
    return depth;
  endfunction

endpackage

// File: rtl/delay_chain_sensor_if.sv
// Request/result bundle of the delay sensor; min/max exist only with DELAY_SENSOR_MINMAX_EN.
interface delay_chain_sensor_if #(
  parameter int NUM_STAGES   = 50,
  parameter int SAMPLES_LOG2 = 4
) ();
  localparam int CNT_W = delay_sensor_pkg::cnt_width(NUM_STAGES);

  logic                          start;
  logic                          busy;
  logic                          done;
  logic [CNT_W+SAMPLES_LOG2-1:0] result;
  logic [CNT_W-1:0]              last_count;
`ifdef DELAY_SENSOR_MINMAX_EN
  logic [CNT_W-1:0]              min_count;
  logic [CNT_W-1:0]              max_count;

  modport master (output start, input busy, done, result, last_count, min_count, max_count);
  modport slave  (input start, output busy, done, result, last_count, min_count, max_count);
`else
  modport master (output start, input busy, done, result, last_count);
  modport slave  (input start, output busy, done, result, last_count);
`endif
endinterface

// File: rtl/delay_chain_taps.sv
// Unclocked chain of inverting stages; every stage output is exported as a tap.
module delay_chain_taps #(
  parameter int NUM_STAGES = 50
) (
  output logic [NUM_STAGES-1:0] taps,
  input  logic                  chain_in
);

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    (* keep *) logic n;
    if (k == 0) begin : g_first
      assign n = ~chain_in;
    end else begin : g_next
      assign n = ~g_stage[k-1].n;
    end
    assign taps[k] = n;
  end

endmodule

// File: rtl/delay_chain_sensor.sv
// Delay sensor top: launch/capture FSM, encoder and accumulator.
// Optional min/max tracking under DELAY_SENSOR_MINMAX_EN.
//   state   | meaning
//   IDLE    | wait for start
//   LAUNCH  | toggle chain input
//   CAPTURE | register taps one period after launch
//   SYNC    | second flop for metastability
//   ENCODE  | depth -> last_count, accumulate
//   SETTLE  | let the chain settle, then next sample or finish
//   DONE    | publish result
module delay_chain_sensor
  import delay_sensor_pkg::*;
#(
  parameter int NUM_STAGES    = 50,
  parameter int SAMPLES_LOG2  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  delay_chain_sensor_if.slave    bus
);

  localparam int CNT_W = cnt_width(NUM_STAGES);
  localparam int ACC_W = CNT_W + SAMPLES_LOG2;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = SAMPLES_LOG2 + 1;
  localparam logic [SMP_W-1:0] NUM_SAMPLES = SMP_W'(1 << SAMPLES_LOG2);

  state_t                state, state_next;
  logic                  launch_q;
  logic [NUM_STAGES-1:0] taps_w, cap_q, sync_q;
  logic [CNT_W-1:0]      depth, last_count_q;
  logic [ACC_W-1:0]      acc_q, result_q;
  logic [SMP_W-1:0]      smp_q;
  logic [SET_W-1:0]      settle_q;
  logic                  done_q, busy_q;
`ifdef DELAY_SENSOR_MINMAX_EN
  logic [CNT_W-1:0]      min_q, max_q;
`endif

  delay_chain_taps #(.NUM_STAGES(NUM_STAGES)) u_taps (
    .taps     (taps_w),
    .chain_in (launch_q)
  );

  assign depth = CNT_W'(tap_depth(MAX_STAGES'(sync_q), NUM_STAGES, launch_q));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LAUNCH;
      LAUNCH:  state_next = CAPTURE;
      CAPTURE: state_next = SYNC;
      SYNC:    state_next = ENCODE;
      ENCODE:  state_next = SETTLE;
      SETTLE:  if (settle_q == '0) state_next = (smp_q < NUM_SAMPLES) ? LAUNCH : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      launch_q     <= 1'b0;
      cap_q        <= '0;
      sync_q       <= '0;
      last_count_q <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      smp_q        <= '0;
      settle_q     <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DELAY_SENSOR_MINMAX_EN
      min_q        <= '0;
      max_q        <= '0;
`endif
    end else begin
      state  <= state_next;
      // busy stays up through the cycle in which done is visible
      busy_q <= (state_next != IDLE) || (state == DONE);
      done_q <= (state == DONE);
      case (state)
        IDLE: if (bus.start) begin
          acc_q <= '0;
          smp_q <= '0;
`ifdef DELAY_SENSOR_MINMAX_EN
          min_q <= CNT_W'(NUM_STAGES);
          max_q <= '0;
`endif
        end
        LAUNCH:  launch_q <= ~launch_q;
        CAPTURE: cap_q    <= taps_w;
        SYNC:    sync_q   <= cap_q;
        ENCODE: begin
          last_count_q <= depth;
          acc_q        <= acc_q + ACC_W'(depth);
          smp_q        <= smp_q + 1'b1;
          settle_q     <= SET_W'(SETTLE_CYCLES - 1);
`ifdef DELAY_SENSOR_MINMAX_EN
          if (depth < min_q) min_q <= depth;
          if (depth > max_q) max_q <= depth;
`endif
        end
        SETTLE:  if (settle_q != '0) settle_q <= settle_q - 1'b1;
        DONE:    result_q <= acc_q;
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.last_count = last_count_q;
`ifdef DELAY_SENSOR_MINMAX_EN
  assign bus.min_count  = min_q;
  assign bus.max_count  = max_q;
`endif

endmodule

// File: tb/tb_delay_chain_sensor.sv
// Bench for delay_chain_sensor: forced tap patterns on a 4-sample instance,
// free-running zero-delay chain on a 16-sample instance.
module tb_delay_chain_sensor;
  import delay_sensor_pkg::*;

  localparam int NS = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_chain_sensor_if #(.NUM_STAGES(NS), .SAMPLES_LOG2(2)) bus ();
  delay_chain_sensor_if #(.NUM_STAGES(NS), .SAMPLES_LOG2(4)) bus16 ();

  delay_chain_sensor #(.NUM_STAGES(NS), .SAMPLES_LOG2(2), .SETTLE_CYCLES(4)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  delay_chain_sensor #(.NUM_STAGES(NS), .SAMPLES_LOG2(4), .SETTLE_CYCLES(4)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );

  int errors = 0;
  int checks = 0;
  int sched [4];
  int sidx = -1;
  logic [NS-1:0] tb_taps = '0;

  typedef struct {
    int d0, d1, d2, d3;
    int res, last, mn, mx;
  } vec_t;
  vec_t vecs [6];

  // Tap pattern whose polarity-corrected run length is d, with random bits after the break.
  function automatic logic [NS-1:0] make_taps(input int d, input logic lvl);
    logic [NS-1:0] t;
    logic nb;
    for (int k = 0; k < NS; k++) begin
      if (k < d) nb = lvl;
      else if (k == d) nb = ~lvl;
      else nb = 1'($urandom);
      t[k] = nb ^ (k % 2 == 0);
    end
    return t;
  endfunction

  always @(dut.launch_q) begin
    sidx++;
    tb_taps = make_taps(sched[sidx & 3], dut.launch_q);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_meas(output int lat);
    lat = -1;
    sidx = -1;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic run_meas16(output int lat, output int last_at4);
    lat = -1;
    last_at4 = -1;
    @(negedge clk); bus16.start = 1'b1;
    @(posedge clk); #1 bus16.start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 4) last_at4 = int'(bus16.last_count);
      if (bus16.done === 1'b1) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat, l4, ndone, sum, mn, mx;

    vecs[0] = '{17, 17, 17, 17, 68, 17, 17, 17};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{10, 30, 10, 30, 80, 30, 10, 30};
    vecs[3] = '{50, 50, 50, 50, 200, 50, 50, 50};
    vecs[4] = '{49, 1, 0, 25, 75, 25, 0, 49};
    vecs[5] = '{3, 44, 12, 7, 66, 7, 3, 44};

    force dut.taps_w = tb_taps;
    bus.start = 1'b0;
    bus16.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_last", bus.last_count, 0);
    check("rst_launch", dut.launch_q, 0);
`ifdef DELAY_SENSOR_MINMAX_EN
    check("rst_min", bus.min_count, 0);
    check("rst_max", bus.max_count, 0);
`endif
    @(negedge clk) rst = 1'b0;

    // Zero-delay chain, 16 samples
    run_meas16(lat, l4);
    check("zd_latency", lat, 129);
    check("zd_busy_at_done", bus16.busy, 1);
    check("zd_first_last", l4, 50);
    check("zd_last", bus16.last_count, 50);
    check("zd_result", bus16.result, 800);
    @(posedge clk); #1;
    check("zd_busy_after", bus16.busy, 0);
    check("zd_done_after", bus16.done, 0);

    for (int i = 0; i < 6; i++) begin
      sched[0] = vecs[i].d0; sched[1] = vecs[i].d1;
      sched[2] = vecs[i].d2; sched[3] = vecs[i].d3;
      run_meas(lat);
      check($sformatf("vec%0d_latency", i), lat, 33);
      check($sformatf("vec%0d_busy", i), bus.busy, 1);
      check($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
      check($sformatf("vec%0d_last", i), bus.last_count, vecs[i].last);
`ifdef DELAY_SENSOR_MINMAX_EN
      check($sformatf("vec%0d_min", i), bus.min_count, vecs[i].mn);
      check($sformatf("vec%0d_max", i), bus.max_count, vecs[i].mx);
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle", i), bus.busy, 0);
    end

    for (int r = 0; r < 20; r++) begin
      sum = 0; mn = NS; mx = 0;
      for (int j = 0; j < 4; j++) begin
        sched[j] = int'($urandom_range(0, NS));
        sum += sched[j];
        if (sched[j] < mn) mn = sched[j];
        if (sched[j] > mx) mx = sched[j];
      end
      run_meas(lat);
      check($sformatf("rnd%0d_latency", r), lat, 33);
      check($sformatf("rnd%0d_result", r), bus.result, sum);
      check($sformatf("rnd%0d_last", r), bus.last_count, sched[3]);
`ifdef DELAY_SENSOR_MINMAX_EN
      check($sformatf("rnd%0d_min", r), bus.min_count, mn);
      check($sformatf("rnd%0d_max", r), bus.max_count, mx);
`endif
      @(posedge clk); #1;
    end

    // start pulsed while busy must not restart or add a second done
    for (int j = 0; j < 4; j++) sched[j] = 20;
    sidx = -1;
    ndone = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      if (k == 10) bus.start = 1'b1;
      if (k == 11) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        check("busy_start_latency", k, 33);
      end
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_result", bus.result, 80);

    // Reset in cycle 40 of a 16-sample measurement
    @(negedge clk); bus16.start = 1'b1;
    @(posedge clk); #1 bus16.start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", dut16.state, IDLE);
    check("midrst_busy", bus16.busy, 0);
    check("midrst_done", bus16.done, 0);
    check("midrst_result", bus16.result, 0);
    check("midrst_last", bus16.last_count, 0);
    check("midrst_launch", dut16.launch_q, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (bus16.done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_meas16(lat, l4);
    check("postrst_latency", lat, 129);
    check("postrst_result", bus16.result, 800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
